text_overlay: RTL and testbench

Character-cell text generator feeding `video_encoder`. It takes the `vga_sync` timing, renders an 80x30 grid of 8x16 glyphs from a host-writable character buffer, and drives RGB plus delayed blank/hsync/vsync. It replaces `test_pattern` for status display, such as arm state and countdown text. A built-in clear engine fills the buffer with spaces after reset or on request.

---
 rtl/text_overlay_pkg.sv | 17 +
 rtl/text_overlay_if.sv | 17 +
 rtl/text_overlay_font_rom.sv | 30 +++
 rtl/text_overlay.sv | 114 +++++++++++
 tb/tb_text_overlay.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: shared constants, clear-FSM state type and cell address helper
package text_overlay_pkg;
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int CELLS   = 2400;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;
    localparam logic [11:0] LAST_CELL  = 12'(CELLS - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    // row*80 + col as row*64 + row*16 + col, so no multiplier is inferred
    function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        return {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, col};
    endfunction
endpackage

// File: rtl/text_overlay_if.sv
// text_overlay_if: video timing in/out, host character-write port and clear control
//   master: drives blank/hsync/vsync, wr_en/wr_addr/wr_data, clr_req
//   slave : drives busy, delayed blank/hsync/vsync and red/green/blue
interface text_overlay_if;
    logic       blank, hsync, vsync;
    logic       wr_en;
    logic [11:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_req, busy;
    logic       blank_out, hsync_out, vsync_out;
    logic [7:0] red, green, blue;

    modport master (output blank, hsync, vsync, wr_en, wr_addr, wr_data, clr_req,
                    input  busy, blank_out, hsync_out, vsync_out, red, green, blue);
    modport slave  (input  blank, hsync, vsync, wr_en, wr_addr, wr_data, clr_req,
                    output busy, blank_out, hsync_out, vsync_out, red, green, blue);
endinterface

// File: rtl/text_overlay_font_rom.sv
// font_rom: 128 glyphs x 16 rows x 8 bits, synchronous read, bit 7 = leftmost pixel
//   clk  : pixel clock
//   addr : {code[6:0], glyph_row[3:0]}
//   data : glyph row byte, valid the cycle after addr
// Holds 'A' as a real glyph, space as blank, and a code-stamp pattern for the rest
// until a full font table is dropped in.
module font_rom
    import text_overlay_pkg::*;
(
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;

    logic [6:0] code;
    logic [3:0] r;
    logic [7:0] rom_byte;

    assign code = addr[10:4];
    assign r    = addr[3:0];

    always_comb
        rom_byte = (code == 7'h41) ? GLYPH_A[{~r, 3'b111} -: 8] :
                   (code == CHAR_SPACE[6:0] || r == 4'd0 || r == 4'(GLYPH_H - 1)) ? 8'h00 :
                   {1'b1, code};

    always_ff @(posedge clk)
        data <= rom_byte;
endmodule

// File: rtl/text_overlay.sv
// text_overlay: 80x30 character-cell text renderer with clear engine, 3-cycle pipeline
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : text_overlay_if.slave (timing in, host writes, clr_req, busy, delayed syncs, RGB)
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic      clk,
    input  logic      reset,
    text_overlay_if.slave bus
);
    logic [9:0]  x, y;
    logic [11:0] addr1;
    logic [2:0]  pb1, pb2, pb3;
    logic [3:0]  gr1, gr2;
    logic        oog1, oog2, oog3, attr3;
    logic [2:0]  sync1, sync2, sync3;
    logic [7:0]  ram [CELLS];
    logic [7:0]  ch, glyph;
    clr_state_t  state, state_n;
    logic [11:0] clr_addr, clr_addr_n;
    logic        busy, we, pix_on;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic [23:0] rgb;

    // sync bundles are {blank, hsync, vsync}; sync1[2] doubles as "previous blank"
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            x     <= '0;
            y     <= '0;
            addr1 <= '0;
            pb1   <= '0;
            pb2   <= '0;
            pb3   <= '0;
            gr1   <= '0;
            gr2   <= '0;
            oog1  <= 1'b0;
            oog2  <= 1'b0;
            oog3  <= 1'b0;
            attr3 <= 1'b0;
            sync1 <= 3'b100;
            sync2 <= 3'b100;
            sync3 <= 3'b100;
        end else begin
            x     <= bus.blank ? '0 : x + 10'd1;
            y     <= bus.vsync ? '0 : (bus.blank && !sync1[2]) ? y + 10'd1 : y;
            addr1 <= cell_addr(y[9:4], x[9:3]);
            pb1   <= x[2:0];
            gr1   <= y[3:0];
            oog1  <= x[9:3] >= 7'(COLS) || y[9:4] >= 6'(ROWS);
            sync1 <= {bus.blank, bus.hsync, bus.vsync};
            sync2 <= sync1;
            sync3 <= sync2;
            pb2   <= pb1;
            pb3   <= pb2;
            gr2   <= gr1;
            oog2  <= oog1;
            oog3  <= oog2;
            attr3 <= ch[7];
        end

    // read-before-write: a same-cycle read of the written cell returns the old byte
    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= wdata;
        ch <= ram[addr1];
    end

    font_rom u_font (
        .clk  (clk),
        .addr ({ch[6:0], gr2}),
        .data (glyph)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
        end

    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        if (state == CLEAR) begin
            clr_addr_n = clr_addr + 12'd1;
            state_n    = (clr_addr == LAST_CELL) ? IDLE : CLEAR;
        end else if (bus.clr_req) begin
            state_n    = CLEAR;
            clr_addr_n = '0;
        end
    end

    // the clear engine owns the write port; host writes are dropped while busy
    assign busy  = state == CLEAR;
    assign we    = busy || (bus.wr_en && bus.wr_addr < 12'(CELLS));
    assign waddr = busy ? clr_addr : bus.wr_addr;
    assign wdata = busy ? CHAR_SPACE : bus.wr_data;

    assign pix_on = glyph[3'(GLYPH_W - 1) - pb3] ^ attr3;
    assign rgb    = sync3[2] ? 24'h0 : (oog3 || !pix_on) ? BG_COLOR : FG_COLOR;

    assign bus.busy      = busy;
    assign bus.blank_out = sync3[2];
    assign bus.hsync_out = sync3[1];
    assign bus.vsync_out = sync3[0];
    assign {bus.red, bus.green, bus.blue} = rgb;
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: self-checking bench for text_overlay against a cell/frame reference model
module tb_text_overlay;
    import text_overlay_pkg::*;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    text_overlay_if bus();

    text_overlay dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {logic b, h, v, chk; logic [23:0] rgb;} exp_t;
    typedef struct {bit b, h, v, eb, eh, ev;} vec_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] mem [CELLS];
    bit         known [CELLS];
    int         mx, my, m_caddr;
    bit         prev_blank, m_busy;

    function automatic logic [7:0] glyph_row(input int code, input int r);
        logic [7:0] a [16];
        a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
              8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
        if (code == 65) return a[r];
        if (code == 32 || r == 0 || r == 15) return 8'h00;
        return 8'h80 | 8'(code);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_caddr = 0;
        mx = 0;
        my = 0;
        prev_blank = 1'b1;
        q.delete();
        q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'h0});
        q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'h0});
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_blank_out"}, 32'(bus.blank_out), 32'd1);
        check({tag, "_hsync_out"}, 32'(bus.hsync_out), 32'd0);
        check({tag, "_vsync_out"}, 32'(bus.vsync_out), 32'd0);
        check({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    // one pixel clock: drive, clock, advance model, compare
    task automatic step(input bit b, input bit h, input bit v, input bit we = 1'b0,
                        input int wa = 0, input logic [7:0] wd = 8'h00, input bit cr = 1'b0);
        exp_t e;
        int col, row, idx;
        logic [7:0] c, g;
        bit on;
        bus.blank = b;
        bus.hsync = h;
        bus.vsync = v;
        bus.wr_en = we;
        bus.wr_addr = 12'(wa);
        bus.wr_data = wd;
        bus.clr_req = cr;
        @(posedge clk);
        #1;
        if (m_busy) begin
            mem[m_caddr] = 8'h20;
            known[m_caddr] = 1'b1;
            m_caddr++;
            if (m_caddr == CELLS) m_busy = 1'b0;
        end else begin
            if (we && wa < CELLS) begin
                mem[wa] = wd;
                known[wa] = 1'b1;
            end
            if (cr) begin
                m_busy = 1'b1;
                m_caddr = 0;
            end
        end
        e = '{b, h, v, 1'b1, 24'h0};
        col = mx / 8;
        row = my / 16;
        if (!b) begin
            if (col >= 80 || row >= 30) e.rgb = BG;
            else begin
                idx = row * 80 + col;
                c = mem[idx];
                e.chk = known[idx];
                g = glyph_row(int'(c[6:0]), my % 16);
                on = g[7 - (mx % 8)] ^ c[7];
                e.rgb = on ? FG : BG;
            end
        end
        q.push_back(e);
        mx = b ? 0 : (mx + 1) % 1024;
        my = v ? 0 : (b && !prev_blank) ? (my + 1) % 1024 : my;
        prev_blank = b;
        e = q.pop_front();
        check("blank_out", 32'(bus.blank_out), 32'(e.b));
        check("hsync_out", 32'(bus.hsync_out), 32'(e.h));
        check("vsync_out", 32'(bus.vsync_out), 32'(e.v));
        if (e.chk) check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic run_line(input int act, input int blk, input bit rnd);
        bit we, cr;
        int wa;
        for (int i = 0; i < act + blk; i++) begin
            we = rnd && ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2390, 4095)) : int'($urandom_range(0, 250));
            cr = rnd && ($urandom_range(0, 3000) == 0);
            if (i < act) step(1'b0, 1'b0, 1'b0, we, wa, 8'($urandom), cr);
            else step(1'b1, rnd ? 1'($urandom) : (i > act && i < act + blk - 1), 1'b0, we, wa, 8'($urandom), cr);
        end
    endtask

    task automatic vsync_gap();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic count_clear(input string name);
        int cnt = 0;
        while (bus.busy && cnt < 3000) begin
            step(1'b1, 1'b0, 1'b0, cnt == 500, 1, 8'h41, cnt == 1000);
            cnt++;
        end
        check(name, 32'(cnt), 32'd2400);
    endtask

    initial begin
        vec_t vt [8];
        vt = '{'{1,1,0, 1,0,0}, '{1,0,1, 1,0,0}, '{0,0,0, 1,1,0}, '{1,1,1, 1,0,1},
               '{1,0,0, 0,0,0}, '{0,1,0, 1,1,1}, '{1,0,0, 1,0,0}, '{1,0,1, 0,1,0}};
        bus.blank = 1'b1;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("por");
        reset = 1'b0;
        model_reset();
        count_clear("clear_cycles");

        repeat (4) step(1'b1, 1'b0, 1'b0);
        foreach (vt[i]) begin
            step(vt[i].b, vt[i].h, vt[i].v);
            check("lat_blank", 32'(bus.blank_out), 32'(vt[i].eb));
            check("lat_hsync", 32'(bus.hsync_out), 32'(vt[i].eh));
            check("lat_vsync", 32'(bus.vsync_out), 32'(vt[i].ev));
        end
        repeat (3) step(1'b1, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h41);
        step(1'b1, 1'b0, 1'b0, 1'b1, 81, 8'hC1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2400, 8'h41);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4095, 8'h41);
        step(1'b1, 1'b0, 1'b0, 1'b1, 80, 8'hA0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2320, 8'hA0);

        vsync_gap();
        for (int l = 0; l < 36; l++) run_line(24, 4, 1'b0);
        vsync_gap();
        for (int l = 0; l < 4; l++) run_line(1040, 4, 1'b0);
        vsync_gap();
        for (int l = 0; l < 1040; l++) run_line(8, 2, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
        while (m_caddr < 1000) step(1'b0, 1'b1, 1'b1);
        check("pre_reset_vsync", 32'(bus.vsync_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outs("mid_clear");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        count_clear("reclear_cycles");

        vsync_gap();
        for (int l = 0; l < 400; l++) begin
            if ($urandom_range(0, 30) == 0) vsync_gap();
            run_line(int'($urandom_range(1, 48)), int'($urandom_range(2, 6)), 1'b1);
        end
        repeat (4) step(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
